// File: rtl/riscv_test_result_monitor.sv
// rtl/riscv_test_result_monitor.sv - riscv-tests pass/fail/timeout verdict monitor
module riscv_test_result_monitor #(
    parameter logic [31:0] END_PC     = 32'h0000_0044,
    parameter int          RESULT_REG = 3,
    parameter logic [31:0] PASS_VALUE = 32'h0000_0001,
    parameter int          TIMEOUT    = 5000,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic             retire_valid,
    input  logic [31:0]      retire_pc,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [31:0]      wb_data,
    output logic             done,
    output logic             passed,
    output logic             failed,
    output logic             timed_out,
    output logic [30:0]      fail_test_num,
    output logic [CNT_W-1:0] cycles
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        PASS = 3'd2,
        FAIL = 3'd3,
        TMO  = 3'd4
    } state_t;

    // Last RUN cycle index before timeout; widened so a TIMEOUT beyond the
    // counter range simply never matches and the counter saturates instead.
    localparam logic [63:0] TMO_LAST = 64'(TIMEOUT) - 64'd1;

    state_t            state;
    state_t            next_state;
    logic [31:0]       shadow;
    logic              res_hit;
    logic [31:0]       effective;
    logic              end_evt;
    logic              tmo_hit;
    logic              verdict;
    logic [CNT_W-1:0]  cycles_inc;

    assign res_hit    = wb_en && (wb_addr == 5'(RESULT_REG)) && (wb_addr != 5'd0);
    assign effective  = res_hit ? wb_data : shadow;
    assign end_evt    = retire_valid && (retire_pc == END_PC);
    assign tmo_hit    = (64'(cycles) == TMO_LAST);
    assign verdict    = (state == PASS) || (state == FAIL) || (state == TMO);
    assign cycles_inc = (cycles == {CNT_W{1'b1}}) ? cycles : cycles + 1'b1;

    assign done      = verdict;
    assign passed    = (state == PASS);
    assign failed    = (state == FAIL);
    assign timed_out = (state == TMO);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: clear beats everything, end event beats timeout
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start && !clear) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (clear) begin
                    next_state = IDLE;
                end else if (end_evt) begin
                    next_state = (effective == PASS_VALUE) ? PASS : FAIL;
                end else if (tmo_hit) begin
                    next_state = TMO;
                end
            end
            PASS, FAIL, TMO: begin
                if (clear) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Shadow of the result register, tracked in every state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= 32'd0;
        end else if (res_hit) begin
            shadow <= wb_data;
        end
    end

    // Cycle counter and failing test number
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles        <= '0;
            fail_test_num <= 31'd0;
        end else if (state == IDLE) begin
            if (next_state == RUN) begin
                cycles <= '0;
            end
        end else if (state == RUN) begin
            if (clear) begin
                cycles        <= '0;
                fail_test_num <= 31'd0;
            end else begin
                cycles <= cycles_inc;
                if (next_state == FAIL) begin
                    fail_test_num <= effective[31:1];
                end
            end
        end else if (clear) begin
            cycles        <= '0;
            fail_test_num <= 31'd0;
        end
    end

endmodule

// File: doc/riscv_test_result_monitor.md
Name: riscv_test_result_monitor

Overview:
- Synthesizable pass/fail monitor; sits directly downstream of the core and consumes its retire and register write-back streams.
- Keeps a shadow copy of the riscv-tests result register (gp/x3) and detects arrival at the test end address.
- Produces a sticky verdict (pass / fail with failing test number / timeout) and a cycle count.
- Lets benches and FPGA builds read the verdict from a status port instead of probing core internals.

Parameters:
- END_PC, 32'h0000_0044, retired PC that marks end of test
- RESULT_REG, 3, register index holding the test status (gp)
- PASS_VALUE, 32'h0000_0001, result register value meaning pass
- TIMEOUT, 5000, RUN cycles allowed before timeout verdict (≥1)
- CNT_W, 32, width of cycle counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  pulse: begin monitoring (accepted only in IDLE)
- clear  in  1  pulse: drop verdict, return to IDLE
- retire_valid  in  1  an instruction retires this cycle
- retire_pc  in  32  PC of the retiring instruction
- wb_en  in  1  register write-back enable
- wb_addr  in  5  write-back destination register
- wb_data  in  32  write-back data
- done  out  1  verdict available (sticky)
- passed  out  1  verdict = pass
- failed  out  1  verdict = fail
- timed_out  out  1  verdict = timeout
- fail_test_num  out  31  shadow[31:1] latched at fail; 0 otherwise
- cycles  out  CNT_W  RUN cycles elapsed (frozen at verdict)

Behaviour:
- Reset (async, asserted immediately on rst high):
  - state=IDLE, shadow=0, cycles=0, fail_test_num=0.
  - done, passed, failed and timed_out all 0.
- States: IDLE, RUN, PASS, FAIL, TMO. Outputs are registered and decoded from state:
  - done=1 in PASS/FAIL/TMO.
  - passed=1 in PASS, failed=1 in FAIL, timed_out=1 in TMO.
- Shadow register update:
  - Updated in every state on wb_en && wb_addr==RESULT_REG && wb_addr!=0.
  - Writes to other registers are ignored.
- IDLE:
  - start=1 → RUN next cycle; cycles cleared to 0; shadow keeps its value.
- RUN:
  - cycles increments by 1 each cycle.
  - End check: retire_valid && retire_pc==END_PC. The effective result is wb_data when a same-cycle write to RESULT_REG occurs (bypass), otherwise the shadow.
  - Effective result == PASS_VALUE → PASS.
  - Otherwise → FAIL; fail_test_num latched from effective[31:1].
  - No end event and cycles == TIMEOUT-1 → TMO next cycle, so TMO is entered after exactly TIMEOUT RUN cycles and cycles reads TIMEOUT.
  - End event in the same cycle as the timeout condition: the end event wins.
  - start is ignored.
- PASS/FAIL/TMO:
  - Sticky; cycles frozen; retire and start are ignored.
  - clear=1 → IDLE, with cycles and fail_test_num zeroed.
- clear in RUN → IDLE (aborts). clear has priority over start and the end event. clear in IDLE has no effect.
- cycles never wraps: TIMEOUT bounds it. If TIMEOUT ≥ 2^CNT_W, cycles saturates at all-ones.
- Latency: verdict outputs go high on the clock edge after the retire cycle at END_PC (1 cycle).
- Reset asserted mid-RUN or mid-verdict returns everything to reset values at once. There is no auto-start after reset.

Test Plan:
- Reset, start, write x3=1 at cycle 10, retire pc=0x44 at cycle 20 → passed=1, done=1 one cycle later, cycles=21, fail_test_num=0.
- Write x3=0x0000_000B, then retire pc=0x44 → failed=1, fail_test_num=5, passed=0.
- Same cycle: wb_en, wb_addr=3, wb_data=1 and retire pc=0x44 while shadow=0x7 → passed=1 (bypass).
- Start with TIMEOUT=16 and no retire at END_PC → timed_out=1 after exactly 16 RUN cycles, cycles=16. Separately, an end event on the final cycle yields pass/fail, not timeout.
- Retire pc=0x44 while in IDLE, and writes to x0 or x4 with value 1 → no verdict, shadow unchanged. Retire at END_PC after PASS → verdict unchanged.
- Assert rst asynchronously mid-RUN (between edges) → all outputs 0 immediately. Then: clear in PASS → IDLE, done=0; start → RUN with cycles restarting from 0.
